// File: rtl/md_issue_if.sv
// md_issue_if: pipeline <-> issue controller <-> multdiv signal bundle.
// MD_PERF_EN adds the stall_cnt performance counter output.
interface md_issue_if;
    logic       id_md_start;
    logic       id_md_read;
    logic       id_md_write;
    logic       ex_md_start;
    logic [2:0] ex_md_op;
    logic       ex_hiwrite;
    logic       ex_lowrite;
    logic       ex_flush;
    logic       md_busy;
    logic       md_start;
    logic [2:0] md_mdctr;
    logic       md_hiwrite;
    logic       md_lowrite;
    logic       stall_md;
    logic [1:0] md_state;
    logic       md_err;
`ifdef MD_PERF_EN
    logic [31:0] stall_cnt;
`endif

    modport slave (
        input  id_md_start, id_md_read, id_md_write, ex_md_start, ex_md_op,
               ex_hiwrite, ex_lowrite, ex_flush, md_busy,
`ifdef MD_PERF_EN
        output stall_cnt,
`endif
        output md_start, md_mdctr, md_hiwrite, md_lowrite, stall_md, md_state, md_err
    );

    modport master (
        output id_md_start, id_md_read, id_md_write, ex_md_start, ex_md_op,
               ex_hiwrite, ex_lowrite, ex_flush, md_busy,
`ifdef MD_PERF_EN
        input  stall_cnt,
`endif
        input  md_start, md_mdctr, md_hiwrite, md_lowrite, stall_md, md_state, md_err
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: EX-stage issue/stall controller mirroring multdiv latency.
// MD_PERF_EN adds a saturating count of stall_md cycles (stall_cnt).
module md_issue_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input logic     clk,
    input logic     rst,
    md_issue_if.slave md
);
    typedef enum logic [1:0] {IDLE = 2'b00, RUN_MUL = 2'b01, RUN_DIV = 2'b10} state_e;

    localparam logic [3:0] MUL_END = 4'(MULT_LAT);
    localparam logic [3:0] DIV_END = 4'(DIV_LAT);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       armed_q, armed_d;
    logic       busy, issue_ok, start, last, stall;

    always_comb begin
        busy     = state_q != IDLE;
        issue_ok = ~md.ex_flush & ~busy;
        start    = md.ex_md_start & issue_ok;
        last     = cnt_q == (state_q == RUN_MUL ? MUL_END : DIV_END);
        state_d  = start ? (md.ex_md_op[1] ? RUN_DIV : RUN_MUL) : (busy & last) ? IDLE : state_q;
        cnt_d    = start ? 4'd1 : busy ? (last ? 4'd0 : cnt_q + 4'd1) : cnt_q;
        // busy mismatch is only trusted once multdiv has been seen idle
        err_d    = err_q | (md.ex_md_start & ~md.ex_flush & (busy | md.ex_hiwrite | md.ex_lowrite))
                 | (armed_q & (md.md_busy != busy));
        armed_d  = armed_q | (~busy & ~md.md_busy);
        stall    = rst & (md.id_md_start | md.id_md_read | md.id_md_write) & (busy | start);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            armed_q <= armed_d;
        end
    end

    assign md.md_start   = rst & start;
    assign md.md_mdctr   = (rst & md.ex_md_start) ? md.ex_md_op : 3'b000;
    assign md.md_hiwrite = rst & md.ex_hiwrite & issue_ok & ~md.ex_md_start;
    assign md.md_lowrite = rst & md.ex_lowrite & issue_ok & ~md.ex_md_start;
    assign md.stall_md   = stall;
    assign md.md_state   = rst ? state_q : 2'b00;
    assign md.md_err     = rst & err_q;

`ifdef MD_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst)
            stall_cnt_q <= 32'd0;
        else if (stall & ~&stall_cnt_q)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign md.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: directed per-cycle vectors; expected outputs are queued
// by the stimulus and compared by an independent negedge monitor.
module tb_md_issue_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    md_issue_if bus ();
    md_issue_ctrl dut (.clk(clk), .rst(rst), .md(bus));

    typedef struct {
        string      tag;
        logic       start;
        logic [2:0] ctr;
        logic       hw;
        logic       lw;
        logic       stall;
        logic [1:0] state;
        logic       err;
    } exp_t;

    exp_t q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    task automatic step(input string tag, input logic r, input logic ids, input logic idr,
                        input logic idw, input logic exs, input logic [2:0] op, input logic hw,
                        input logic lw, input logic fl, input logic busy, input logic e_start,
                        input logic [2:0] e_ctr, input logic e_hw, input logic e_lw,
                        input logic e_stall, input logic [1:0] e_state, input logic e_err);
        exp_t e;
        @(posedge clk);
        #1;
        rst             = r;
        bus.id_md_start = ids;
        bus.id_md_read  = idr;
        bus.id_md_write = idw;
        bus.ex_md_start = exs;
        bus.ex_md_op    = op;
        bus.ex_hiwrite  = hw;
        bus.ex_lowrite  = lw;
        bus.ex_flush    = fl;
        bus.md_busy     = busy;
        e = '{tag, e_start, e_ctr, e_hw, e_lw, e_stall, e_state, e_err};
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                n_run++;
                if ({bus.md_start, bus.md_mdctr, bus.md_hiwrite, bus.md_lowrite, bus.stall_md,
                     bus.md_state, bus.md_err} !==
                    {e.start, e.ctr, e.hw, e.lw, e.stall, e.state, e.err}) begin
                    n_fail++;
                    $display("FAIL %s: got start=%b ctr=%b hw=%b lw=%b stall=%b state=%b err=%b, want start=%b ctr=%b hw=%b lw=%b stall=%b state=%b err=%b",
                             e.tag, bus.md_start, bus.md_mdctr, bus.md_hiwrite, bus.md_lowrite,
                             bus.stall_md, bus.md_state, bus.md_err, e.start, e.ctr, e.hw, e.lw,
                             e.stall, e.state, e.err);
                end
            end
        end
    end

`ifdef MD_PERF_EN
    task automatic chk_cnt(input string tag, input logic [31:0] want);
        @(negedge clk);
        n_run++;
        if (bus.stall_cnt !== want) begin
            n_fail++;
            $display("FAIL %s: got stall_cnt=%0d, want %0d", tag, bus.stall_cnt, want);
        end
    endtask
`endif

    initial begin
        {bus.id_md_start, bus.id_md_read, bus.id_md_write, bus.ex_md_start, bus.ex_md_op,
         bus.ex_hiwrite, bus.ex_lowrite, bus.ex_flush, bus.md_busy} = '0;

        // reset with random inputs: everything gated to zero
        for (int i = 0; i < 2; i++)
            step("reset", 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, 3'd0, 0, 0, 0, 2'b00, 0);

        // mult then mflo held in ID: 6 stall cycles
        step("mult_start", 1, 0, 1, 0, 1, 3'b000, 0, 0, 0, 0, 1, 3'b000, 0, 0, 1, 2'b00, 0);
        for (int i = 0; i < 5; i++)
            step("mult_run", 1, 0, 1, 0, 0, 3'd0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 1, 2'b01, 0);
        step("mflo_go", 1, 0, 1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b00, 0);
`ifdef MD_PERF_EN
        chk_cnt("perf_mult", 32'd6);
`endif

        // divu with mult waiting in ID: 11 stall cycles, back-to-back start
        step("divu_start", 1, 1, 0, 0, 1, 3'b011, 0, 0, 0, 0, 1, 3'b011, 0, 0, 1, 2'b00, 0);
        for (int i = 0; i < 10; i++)
            step("divu_run", 1, 1, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 1, 2'b10, 0);
        step("mult_b2b", 1, 0, 0, 0, 1, 3'b000, 0, 0, 0, 0, 1, 3'b000, 0, 0, 0, 2'b00, 0);
        for (int i = 0; i < 5; i++)
            step("mult_run2", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 2'b01, 0);
        step("idle", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b00, 0);

        // mthi/mtlo issue and flush suppression
        step("mthi_flush", 1, 0, 0, 0, 0, 3'd0, 1, 0, 1, 0, 0, 3'd0, 0, 0, 0, 2'b00, 0);
        step("mthi", 1, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0, 0, 3'd0, 1, 0, 0, 2'b00, 0);
        step("mtlo", 1, 0, 0, 0, 0, 3'd0, 0, 1, 0, 0, 0, 3'd0, 0, 1, 0, 2'b00, 0);
        step("start_flush", 1, 1, 0, 0, 1, 3'b010, 0, 0, 1, 0, 0, 3'b010, 0, 0, 0, 2'b00, 0);
        step("mthi_id_rw", 1, 0, 1, 1, 0, 3'd0, 1, 0, 0, 0, 0, 3'd0, 1, 0, 0, 2'b00, 0);

        // start forced during RUN_DIV: dropped, sticky error
        step("div_start", 1, 0, 0, 0, 1, 3'b010, 0, 0, 0, 0, 1, 3'b010, 0, 0, 0, 2'b00, 0);
        step("forced_start", 1, 0, 0, 0, 1, 3'b000, 0, 0, 0, 1, 0, 3'b000, 0, 0, 0, 2'b10, 0);
        for (int i = 0; i < 9; i++)
            step("div_err", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 2'b10, 1);
        step("err_sticky", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b00, 1);
        step("rst_clr", 0, 1, 1, 1, 1, 3'b111, 1, 1, 0, 1, 0, 3'd0, 0, 0, 0, 2'b00, 0);
        step("rst_rel", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b00, 0);

        // multdiv busy drops early
        step("multu_start", 1, 0, 0, 0, 1, 3'b001, 0, 0, 0, 0, 1, 3'b001, 0, 0, 0, 2'b00, 0);
        step("multu_run", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 2'b01, 0);
        step("busy_early", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b01, 0);
        for (int i = 0; i < 3; i++)
            step("busy_err", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b01, 1);
        step("err_hold", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b00, 1);

        // reset mid-divide; stale multdiv busy is masked until seen idle
        step("rst2", 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b00, 0);
        step("div2", 1, 1, 0, 0, 1, 3'b010, 0, 0, 0, 0, 1, 3'b010, 0, 0, 1, 2'b00, 0);
        step("div2_run", 1, 1, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 1, 2'b10, 0);
        step("rst_mid", 0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 2'b00, 0);
        step("rst_mid_rel", 1, 1, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 2'b00, 0);
`ifdef MD_PERF_EN
        chk_cnt("perf_rst", 32'd0);
`endif
        step("busy_masked", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 2'b00, 0);
        step("arm", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b00, 0);
        step("armed_ok", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'b00, 0);

        // start and mthi together: start wins, write dropped, error flagged
        step("start_mthi", 1, 0, 0, 0, 1, 3'b000, 1, 0, 0, 0, 1, 3'b000, 0, 0, 0, 2'b00, 0);
        step("collide_err", 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1, 0, 3'd0, 0, 0, 0, 2'b01, 1);

        repeat (2) @(negedge clk);
        n_run++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
